// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from the read side of a first-word-fall-through FIFO.
// Each popped word goes out as start bit, DWIDTH data bits (LSB first) and
// STOP_BITS stop bits. Frames chain back-to-back while data and enable allow.
module uart_tx_fifo #(
  parameter int DWIDTH       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              fifo_empty_i,
  input  logic [DWIDTH-1:0] fifo_rdata_i,
  output logic              fifo_ren_o,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DWIDTH);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DWIDTH - 1);
  localparam logic          STOP_MAX = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     baud_cnt;
  logic [BW-1:0]     bit_idx;
  logic              stop_idx;
  logic [DWIDTH-1:0] shift;
  logic              baud_wrap, last_stop, pop;

  // Pop decode: a word is taken either from idle or on the very last stop
  // cycle, so consecutive frames abut. Held off while reset is asserted.
  always_comb begin
    baud_wrap = (baud_cnt == BAUD_MAX);
    last_stop = (state == STOP) && baud_wrap && (stop_idx == STOP_MAX);
    pop       = rst_n && en_i && !fifo_empty_i && ((state == IDLE) || last_stop);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; every transition outside IDLE happens on a baud wrap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = START;
      START:   if (baud_wrap) state_nxt = DATA;
      DATA:    if (baud_wrap && (bit_idx == BIT_MAX)) state_nxt = STOP;
      STOP: begin
        if (pop)            state_nxt = START;
        else if (last_stop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: pop strobe is combinational so the FIFO advances in the capture cycle
  always_comb begin
    fifo_ren_o = pop;
    busy_o     = (state != IDLE);
  end

  // Datapath: capture on pop, bit timing, shifting and the registered line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_o     <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
    end else if (pop) begin
      shift    <= fifo_rdata_i;
      baud_cnt <= '0;
      tx_o     <= 1'b0;
    end else if (state != IDLE) begin
      baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
      if (baud_wrap) begin
        case (state)
          START: begin
            bit_idx <= '0;
            tx_o    <= shift[0];
          end
          DATA: begin
            if (bit_idx == BIT_MAX) begin
              tx_o     <= 1'b1;
              stop_idx <= 1'b0;
            end else begin
              shift   <= shift >> 1;
              tx_o    <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end
          STOP: begin
            // final stop without a pop drops to IDLE with the line still high
            if (stop_idx != STOP_MAX) stop_idx <= stop_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (4 clk/bit with 1 stop bit, 3 clk/bit
// with 2 stop bits) fed from queue-modelled FWFT FIFOs. Expected words are
// queued as they are written; a negedge monitor rebuilds each frame's line
// levels from the word and the bit period, and predicts the pop strobe.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en[2], empty[2], ren[2], tx[2], busy[2];
  logic [7:0] rdata[2];

  logic [7:0] fq[2][$];
  logic [7:0] expq[2][$];

  logic live = 1'b0, rst_applied = 1'b0;
  logic end_req = 1'b0;
  int   tmo_cnt = 0;

  int   nvec, errs;
  bit   in_frame[2];
  int   k[2];
  logic [7:0] wexp[2];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DWIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .en_i(en[0]), .fifo_empty_i(empty[0]),
    .fifo_rdata_i(rdata[0]), .fifo_ren_o(ren[0]), .tx_o(tx[0]), .busy_o(busy[0]));

  uart_tx_fifo #(.DWIDTH(8), .CLKS_PER_BIT(3), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en_i(en[1]), .fifo_empty_i(empty[1]),
    .fifo_rdata_i(rdata[1]), .fifo_ren_o(ren[1]), .tx_o(tx[1]), .busy_o(busy[1]));

  function automatic int cpb(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic int flen(input int i);
    return (1 + 8 + ((i == 0) ? 1 : 2)) * cpb(i);
  endfunction

  // ---------------- stimulus side ----------------
  task automatic refresh();
    for (int i = 0; i < 2; i++) begin
      empty[i] = (fq[i].size() == 0);
      rdata[i] = empty[i] ? 8'h00 : fq[i][0];
    end
  endtask

  task automatic push(input int i, input logic [7:0] w);
    fq[i].push_back(w);
    expq[i].push_back(w);
    refresh();
  endtask

  // one clock: sample the pop strobe mid-cycle, advance the FIFO after the edge
  task automatic tick();
    logic p[2];
    @(negedge clk);
    p[0] = ren[0];
    p[1] = ren[1];
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      if (p[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    refresh();
  endtask

  task automatic wait_quiet(input int i);
    int n = 0;
    while (!(busy[i] == 1'b0 && (fq[i].size() == 0 || !en[i])) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) tmo_cnt++;
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    en[0] = 1'b0;
    en[1] = 1'b0;
    refresh();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // single byte
    en[0] = 1'b1;
    push(0, 8'hA5);
    wait_quiet(0);

    // back-to-back frames
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_quiet(0);

    // enable gating: nothing moves while disabled, drop mid-frame stops chaining
    en[0] = 1'b0;
    push(0, 8'h3C);
    push(0, 8'h99);
    repeat (20) tick();
    en[0] = 1'b1;
    repeat (10) tick();
    en[0] = 1'b0;
    wait_quiet(0);
    repeat (20) tick();
    en[0] = 1'b1;
    wait_quiet(0);

    // empty FIFO with enable high, then a late write
    repeat (10) tick();
    push(0, 8'h81);
    wait_quiet(0);

    // reset during data bit 3: first word lost, second sent whole
    push(0, 8'h5A);
    push(0, 8'hC3);
    repeat (18) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_quiet(0);

    // two stop bits, 3 clocks per bit
    en[1] = 1'b1;
    push(1, 8'h55);
    wait_quiet(1);
    push(1, 8'h55);
    push(1, 8'hAA);
    push(1, 8'($urandom));
    wait_quiet(1);

    // random writes and enable toggling on both instances
    repeat (600) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 11) == 0 && fq[i].size() < 3) push(i, 8'($urandom));
      end
      tick();
    end
    en[0] = 1'b1;
    en[1] = 1'b1;
    wait_quiet(0);
    wait_quiet(1);

    // a word left behind while disabled must stay unsent
    en[1] = 1'b0;
    push(1, 8'h42);
    repeat (10) tick();

    end_req = 1'b1;
    repeat (5) tick();
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    rst_applied <= !rst_n;
    live        <= 1'b1;
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40)
        $display("FAIL %s dut%0d t=%0t got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int   seg;
    logic lvl, at_edge;
    if (live) begin
      for (int i = 0; i < 2; i++) begin
        if (rst_applied) begin
          in_frame[i] = 1'b0;
          chk("reset_tx", i, 32'(tx[i]), 32'd1);
          chk("reset_busy", i, 32'(busy[i]), 32'd0);
        end
        if (!in_frame[i] && tx[i] === 1'b0) begin
          chk("frame_has_word", i, 32'(expq[i].size() > 0), 32'd1);
          if (expq[i].size() > 0) wexp[i] = expq[i].pop_front();
          else                    wexp[i] = 8'h00;
          in_frame[i] = 1'b1;
          k[i] = 0;
        end
        if (in_frame[i]) begin
          seg = k[i] / cpb(i);
          if (seg == 0)      lvl = 1'b0;
          else if (seg <= 8) lvl = wexp[i][seg-1];
          else               lvl = 1'b1;
          chk("tx_level", i, 32'(tx[i]), 32'(lvl));
          chk("busy_in_frame", i, 32'(busy[i]), 32'd1);
          at_edge = (k[i] == flen(i) - 1);
        end else begin
          chk("idle_busy", i, 32'(busy[i]), 32'd0);
          at_edge = 1'b1;
        end
        chk("fifo_ren", i, 32'(ren[i]), 32'(at_edge & rst_n & en[i] & ~empty[i]));
        if (in_frame[i]) begin
          k[i]++;
          if (k[i] == flen(i)) in_frame[i] = 1'b0;
        end
      end
      if (end_req) begin
        for (int i = 0; i < 2; i++)
          chk("unsent_words", i, 32'(expq[i].size()), 32'(fq[i].size()));
        chk("wait_timeouts", 0, 32'(tmo_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
      end
    end
  end

endmodule
